pipe_hazard_unit: RTL and testbench
===================================

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameters: XLEN, default 32, forwarded data width; REG_AW, default 5, register-index width; CNT_W, default 32, performance-counter width; MEM_TIMEOUT, default 255, maximum data-memory wait cycles.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with ports listed as name  direction  width  meaning:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have these ID-stage ports:
- id_rs1, id_rs2  in  REG_AW  source register indices.
- id_use_rs1, id_use_rs2  in  1  operand actually read.
- id_is_branch  in  1  compare or jalr resolved in ID.
- id_redirect  in  1  taken branch or jump in ID.
REQ-004 SHALL have these EX, MEM and WB stage ports:
- ex_rd  in  REG_AW; ex_regwrite, ex_memread  in  1.
- mem_rd  in  REG_AW; mem_regwrite, mem_memread  in  1.
- wb_rd  in  REG_AW; wb_regwrite  in  1.
- dmem_req  in  1  MEM stage accessing data memory.
- dmem_ready  in  1  data memory completes this cycle.
REQ-005 SHALL have these pipeline-control outputs, each 1 bit:
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en: register enables.
- if_id_flush: clear IF/ID.
- id_ex_bubble: load a NOP into ID/EX.
REQ-006 SHALL have these forwarding outputs, each 2 bits:
- id_fwd_a, id_fwd_b: ID operand source.
- ex_fwd_a, ex_fwd_b: registered EX operand source.
- Encoding for all four: 0 = register file, 1 = MEM ALU result, 2 = WB write data.
REQ-007 SHALL have these status outputs:
- state  out  2  FSM state.
- mem_err  out  1  sticky timeout flag.
- stall_cnt, flush_cnt, wait_cnt  out  CNT_W  performance counters.

Function
REQ-008 SHALL define match(r, s) as: r != 0, r == s, and the corresponding id_use_* bit is 1.
REQ-009 SHALL raise load_use when ex_memread is 1 and ex_rd matches either id_rs1 or id_rs2.
REQ-010 SHALL raise br_haz when id_is_branch is 1 and either:
- ex_regwrite is 1 and ex_rd matches, or
- mem_memread is 1 and mem_rd matches.
REQ-011 SHALL set stall = load_use OR br_haz.
REQ-012 In state RUN with stall = 1, SHALL drive pc_en = 0, if_id_en = 0, id_ex_bubble = 1, and keep all other enables at 1.
REQ-013 In state RUN, SHALL drive if_id_flush = id_redirect AND NOT stall; a stall suppresses the redirect, which re-evaluates on the next cycle.
REQ-014 SHALL set id_fwd_x as follows:
- 1 when mem_regwrite is 1, mem_memread is 0 and mem_rd matches;
- otherwise 2 when wb_regwrite is 1 and wb_rd matches;
- otherwise 0.
REQ-015 SHALL compute next EX forwarding select per operand as follows:
- 1 when ex_regwrite is 1 and ex_rd matches;
- otherwise 2 when mem_regwrite is 1 and mem_rd matches;
- otherwise 0.
REQ-016 SHALL register the REQ-015 value into ex_fwd_x with one-cycle latency when id_ex_en = 1; it SHALL load 0 on a bubble and hold while frozen.
REQ-017 SHALL implement FSM states RUN = 0, MWAIT = 1 and ERR = 2.
REQ-018 In state RUN with dmem_req = 1 and dmem_ready = 0, SHALL go to MWAIT and combinationally freeze that same cycle: all five enables = 0, id_ex_bubble = 0, if_id_flush = 0.
REQ-019 In state MWAIT, SHALL keep all enables at 0 and return to RUN on the cycle dmem_ready = 1; that cycle SHALL apply the RUN rules.
REQ-020 Memory wait SHALL take priority over stall, and stall SHALL take priority over redirect.
REQ-021 SHALL hold a wait counter, cleared on entry to MWAIT, and go to ERR when it reaches MEM_TIMEOUT.
REQ-022 In state ERR, SHALL set mem_err = 1, keep all enables at 0, and leave ERR only on reset.
REQ-023 Performance counters SHALL count as follows, each saturating at all-ones:
- stall_cnt: increments on each RUN cycle with stall = 1.
- flush_cnt: increments on each cycle with if_id_flush = 1.
- wait_cnt: increments on each frozen cycle.

Reset
REQ-024 While reset = 0, SHALL set state = RUN, ex_fwd_a = ex_fwd_b = 0, mem_err = 0, all counters = 0 and the wait counter = 0.
REQ-025 A reset asserted mid-MWAIT or in ERR SHALL return the block to RUN immediately, asynchronously.

Structure
REQ-026 The FSM state encodings and the forwarding-select encodings SHALL live in the shared ctrl_encode_def definitions.
REQ-027 The block SHALL contain one sub-module, hazard_sat_counter (CNT_W wide, with enable), instantiated three times.

Verification
REQ-028 SHALL cover a load-use hazard: lw x5 in EX (ex_memread = 1, ex_rd = 5) and add in ID with rs1 = 5 -> one cycle of pc_en = 0 and id_ex_bubble = 1; next cycle ex_fwd_a = 2; stall_cnt = 1.
REQ-029 SHALL cover ALU forwarding: ex_regwrite = 1, ex_rd = 3, id_rs2 = 3 -> ex_fwd_b = 1 the cycle after id_ex_en.
REQ-030 SHALL cover a branch after an ALU op: id_is_branch = 1, ex_rd = 7, id_rs1 = 7 -> 1 stall cycle, then id_fwd_a = 1; simultaneous id_redirect gives if_id_flush = 0 while stalled and 1 afterwards.
REQ-031 SHALL cover the x0 case: ex_rd = 0 with ex_memread = 1 and id_rs1 = 0 -> no stall, all forwarding selects 0.
REQ-032 SHALL cover a memory wait: dmem_ready held low for 4 cycles -> all enables 0 for 4 cycles, RUN on cycle 5, wait_cnt = 4.
REQ-033 SHALL cover the timeout: MEM_TIMEOUT = 8 with dmem_ready held low -> ERR and mem_err = 1 after 8 cycles; reset pulse -> RUN with all counters 0.

Source files
------------

// File: rtl/ctrl_encode_def.sv
// Shared control encodings for the pipeline hazard unit: FSM states and
// operand-forwarding source selects.
package ctrl_encode_def;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StMwait = 2'd1,
    StErr   = 2'd2
  } hz_state_e;

  typedef enum logic [1:0] {
    FwdRf  = 2'd0,
    FwdMem = 2'd1,
    FwdWb  = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Pipeline <-> hazard unit bundle: per-stage register/usage info in, stage
// enables, flush/bubble and forwarding selects out.
interface pipe_hazard_unit_if #(
  parameter int unsigned REG_AW = 5
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              id_is_branch;
  logic              id_redirect;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_regwrite;
  logic              mem_memread;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regwrite;
  logic              dmem_req;
  logic              dmem_ready;

  logic              pc_en;
  logic              if_id_en;
  logic              id_ex_en;
  logic              ex_mem_en;
  logic              mem_wb_en;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic [1:0]        id_fwd_a;
  logic [1:0]        id_fwd_b;
  logic [1:0]        ex_fwd_a;
  logic [1:0]        ex_fwd_b;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_branch, id_redirect,
           ex_rd, ex_regwrite, ex_memread, mem_rd, mem_regwrite, mem_memread,
           wb_rd, wb_regwrite, dmem_req, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble,
           id_fwd_a, id_fwd_b, ex_fwd_a, ex_fwd_b
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_branch, id_redirect,
           ex_rd, ex_regwrite, ex_memread, mem_rd, mem_regwrite, mem_memread,
           wb_rd, wb_regwrite, dmem_req, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble,
           id_fwd_a, id_fwd_b, ex_fwd_a, ex_fwd_b
  );
endinterface

// File: rtl/hazard_sat_counter.sv
// Enabled up-counter that sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q;
  logic [Width-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard unit for a 5-stage in-order pipeline with branches resolved in ID:
// load-use/branch stalls, redirect flush, memory-wait freeze with timeout, forwarding.
module pipe_hazard_unit
  import ctrl_encode_def::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_unit_if.slave bus,
  output logic [1:0]        state,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  wait_cnt
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  // XLEN sizes the operand muxes these selects steer; nothing in here is data-wide.
  if (XLEN == 0) begin : g_xlen_unused
  end

  function automatic logic reg_hit(logic [REG_AW-1:0] r, logic [REG_AW-1:0] s, logic use_s);
    return (r != '0) && (r == s) && use_s;
  endfunction

  hz_state_e        state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d, wait_inc;
  fwd_sel_e         ex_fwd_a_q, ex_fwd_b_q;
  fwd_sel_e         ex_sel_a, ex_sel_b, id_sel_a, id_sel_b;

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
  logic load_use, br_haz, stall;
  logic run_rules, frozen;

  assign ex_hit_a  = reg_hit(bus.ex_rd,  bus.id_rs1, bus.id_use_rs1);
  assign ex_hit_b  = reg_hit(bus.ex_rd,  bus.id_rs2, bus.id_use_rs2);
  assign mem_hit_a = reg_hit(bus.mem_rd, bus.id_rs1, bus.id_use_rs1);
  assign mem_hit_b = reg_hit(bus.mem_rd, bus.id_rs2, bus.id_use_rs2);
  assign wb_hit_a  = reg_hit(bus.wb_rd,  bus.id_rs1, bus.id_use_rs1);
  assign wb_hit_b  = reg_hit(bus.wb_rd,  bus.id_rs2, bus.id_use_rs2);

  assign load_use = bus.ex_memread && (ex_hit_a || ex_hit_b);
  // ID-resolved branches can't take a load result from MEM, nor anything from EX.
  assign br_haz   = bus.id_is_branch &&
                    ((bus.ex_regwrite && (ex_hit_a || ex_hit_b)) ||
                     (bus.mem_memread && (mem_hit_a || mem_hit_b)));
  assign stall    = load_use || br_haz;

  always_comb begin
    id_sel_a = FwdRf;
    if (bus.mem_regwrite && !bus.mem_memread && mem_hit_a) id_sel_a = FwdMem;
    else if (bus.wb_regwrite && wb_hit_a)                   id_sel_a = FwdWb;

    id_sel_b = FwdRf;
    if (bus.mem_regwrite && !bus.mem_memread && mem_hit_b) id_sel_b = FwdMem;
    else if (bus.wb_regwrite && wb_hit_b)                   id_sel_b = FwdWb;

    // Producer distances shift by one stage when this instruction reaches EX.
    ex_sel_a = FwdRf;
    if (bus.ex_regwrite && ex_hit_a)        ex_sel_a = FwdMem;
    else if (bus.mem_regwrite && mem_hit_a) ex_sel_a = FwdWb;

    ex_sel_b = FwdRf;
    if (bus.ex_regwrite && ex_hit_b)        ex_sel_b = FwdMem;
    else if (bus.mem_regwrite && mem_hit_b) ex_sel_b = FwdWb;
  end

  assign wait_inc = wait_q + WaitW'(1);

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    run_rules = 1'b0;
    frozen    = 1'b0;
    unique case (state_q)
      StRun: begin
        if (bus.dmem_req && !bus.dmem_ready) begin
          state_d = StMwait;
          wait_d  = '0;
          frozen  = 1'b1;
        end else begin
          run_rules = 1'b1;
        end
      end
      StMwait: begin
        if (bus.dmem_ready) begin
          state_d   = StRun;
          run_rules = 1'b1;
        end else begin
          frozen = 1'b1;
          wait_d = wait_inc;
          if (wait_inc == WaitW'(MEM_TIMEOUT)) state_d = StErr;
        end
      end
      StErr: begin
      end
      default: state_d = StErr;
    endcase
  end

  assign bus.pc_en        = run_rules && !stall;
  assign bus.if_id_en     = run_rules && !stall;
  assign bus.id_ex_en     = run_rules;
  assign bus.ex_mem_en    = run_rules;
  assign bus.mem_wb_en    = run_rules;
  assign bus.id_ex_bubble = run_rules && stall;
  assign bus.if_id_flush  = run_rules && bus.id_redirect && !stall;
  assign bus.id_fwd_a     = id_sel_a;
  assign bus.id_fwd_b     = id_sel_b;
  assign bus.ex_fwd_a     = ex_fwd_a_q;
  assign bus.ex_fwd_b     = ex_fwd_b_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StRun;
      wait_q     <= '0;
      ex_fwd_a_q <= FwdRf;
      ex_fwd_b_q <= FwdRf;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (bus.id_ex_en) begin
        ex_fwd_a_q <= bus.id_ex_bubble ? FwdRf : ex_sel_a;
        ex_fwd_b_q <= bus.id_ex_bubble ? FwdRf : ex_sel_b;
      end
    end
  end

  assign state   = state_q;
  assign mem_err = (state_q == StErr);

  hazard_sat_counter #(.Width(CNT_W)) u_stall_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (run_rules && stall),
    .count_o(stall_cnt)
  );

  hazard_sat_counter #(.Width(CNT_W)) u_flush_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (bus.if_id_flush),
    .count_o(flush_cnt)
  );

  hazard_sat_counter #(.Width(CNT_W)) u_wait_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (frozen),
    .count_o(wait_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed hazard scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_pipe_hazard_unit;

  localparam int unsigned RegAw   = 5;
  localparam int unsigned CntW    = 6;
  localparam int unsigned Timeout = 8;
  localparam int          SatMax  = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      state;
  logic            mem_err;
  logic [CntW-1:0] stall_cnt, flush_cnt, wait_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: mode 0 run, 1 waiting on memory, 2 dead.
  int m_st, m_wc, m_sc, m_fc, m_wt, m_exa, m_exb;

  pipe_hazard_unit_if #(.REG_AW(RegAw)) bus ();

  pipe_hazard_unit #(
    .XLEN       (32),
    .REG_AW     (RegAw),
    .CNT_W      (CntW),
    .MEM_TIMEOUT(Timeout)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .state    (state),
    .mem_err  (mem_err),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
    .wait_cnt (wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit hit(logic [RegAw-1:0] r, logic [RegAw-1:0] s, logic u);
    return (r != 0) && (r == s) && (u == 1'b1);
  endfunction

  task automatic set_idle();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
    bus.id_is_branch = 1'b0; bus.id_redirect = 1'b0;
    bus.ex_rd = '0; bus.ex_regwrite = 1'b0; bus.ex_memread = 1'b0;
    bus.mem_rd = '0; bus.mem_regwrite = 1'b0; bus.mem_memread = 1'b0;
    bus.wb_rd = '0; bus.wb_regwrite = 1'b0;
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b1;
  endtask

  task automatic model_reset();
    m_st = 0; m_wc = 0; m_sc = 0; m_fc = 0; m_wt = 0; m_exa = 0; m_exb = 0;
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_state"},     64'(state),        64'(0));
    chk({pfx, "_mem_err"},   64'(mem_err),      64'(0));
    chk({pfx, "_ex_fwd_a"},  64'(bus.ex_fwd_a), 64'(0));
    chk({pfx, "_ex_fwd_b"},  64'(bus.ex_fwd_b), 64'(0));
    chk({pfx, "_stall_cnt"}, 64'(stall_cnt),    64'(0));
    chk({pfx, "_flush_cnt"}, 64'(flush_cnt),    64'(0));
    chk({pfx, "_wait_cnt"},  64'(wait_cnt),     64'(0));
  endtask

  // Called just after a rising edge; reset is asserted asynchronously mid-cycle.
  task automatic do_reset();
    reset = 1'b0;
    #2;
    check_reset_values("rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  // One clock: check every output against the model at the falling edge, then
  // advance the model across the rising edge.
  task automatic cycle();
    bit e1, e2, m1, m2, w1, w2, stall, wait_now, run;
    int fa, fb, na, nb;
    @(negedge clk);
    e1 = hit(bus.ex_rd,  bus.id_rs1, bus.id_use_rs1);
    e2 = hit(bus.ex_rd,  bus.id_rs2, bus.id_use_rs2);
    m1 = hit(bus.mem_rd, bus.id_rs1, bus.id_use_rs1);
    m2 = hit(bus.mem_rd, bus.id_rs2, bus.id_use_rs2);
    w1 = hit(bus.wb_rd,  bus.id_rs1, bus.id_use_rs1);
    w2 = hit(bus.wb_rd,  bus.id_rs2, bus.id_use_rs2);
    stall = (bus.ex_memread && (e1 || e2)) ||
            (bus.id_is_branch && ((bus.ex_regwrite && (e1 || e2)) ||
                                  (bus.mem_memread && (m1 || m2))));
    wait_now = (m_st == 0 && bus.dmem_req && !bus.dmem_ready) ||
               (m_st == 1 && !bus.dmem_ready);
    run = (m_st != 2) && !wait_now;
    fa = (bus.mem_regwrite && !bus.mem_memread && m1) ? 1 : (bus.wb_regwrite && w1) ? 2 : 0;
    fb = (bus.mem_regwrite && !bus.mem_memread && m2) ? 1 : (bus.wb_regwrite && w2) ? 2 : 0;
    na = (bus.ex_regwrite && e1) ? 1 : (bus.mem_regwrite && m1) ? 2 : 0;
    nb = (bus.ex_regwrite && e2) ? 1 : (bus.mem_regwrite && m2) ? 2 : 0;

    chk("state",        64'(state),            64'(m_st));
    chk("mem_err",      64'(mem_err),          64'(m_st == 2));
    chk("pc_en",        64'(bus.pc_en),        64'(run && !stall));
    chk("if_id_en",     64'(bus.if_id_en),     64'(run && !stall));
    chk("id_ex_en",     64'(bus.id_ex_en),     64'(run));
    chk("ex_mem_en",    64'(bus.ex_mem_en),    64'(run));
    chk("mem_wb_en",    64'(bus.mem_wb_en),    64'(run));
    chk("id_ex_bubble", 64'(bus.id_ex_bubble), 64'(run && stall));
    chk("if_id_flush",  64'(bus.if_id_flush),  64'(run && bus.id_redirect && !stall));
    chk("id_fwd_a",     64'(bus.id_fwd_a),     64'(fa));
    chk("id_fwd_b",     64'(bus.id_fwd_b),     64'(fb));
    chk("ex_fwd_a",     64'(bus.ex_fwd_a),     64'(m_exa));
    chk("ex_fwd_b",     64'(bus.ex_fwd_b),     64'(m_exb));
    chk("stall_cnt",    64'(stall_cnt),        64'(m_sc));
    chk("flush_cnt",    64'(flush_cnt),        64'(m_fc));
    chk("wait_cnt",     64'(wait_cnt),         64'(m_wt));

    if (run && stall && m_sc < SatMax) m_sc++;
    if (run && bus.id_redirect && !stall && m_fc < SatMax) m_fc++;
    if (wait_now && m_wt < SatMax) m_wt++;
    if (run) begin
      m_exa = stall ? 0 : na;
      m_exb = stall ? 0 : nb;
    end
    if (m_st == 0 && wait_now) begin
      m_st = 1;
      m_wc = 0;
    end else if (m_st == 1) begin
      if (bus.dmem_ready) m_st = 0;
      else begin
        m_wc++;
        if (m_wc == Timeout) m_st = 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    set_idle();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Load-use: lw x5 in EX, consumer of x5 in ID.
    bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 5;
    bus.id_rs1 = 5; bus.id_use_rs1 = 1'b1;
    cycle();
    bus.ex_memread = 1'b0; bus.ex_regwrite = 1'b0; bus.ex_rd = 0;
    bus.mem_rd = 5; bus.mem_regwrite = 1'b1; bus.mem_memread = 1'b1;
    cycle();
    chk("lu_ex_fwd_a", 64'(bus.ex_fwd_a), 64'(2));
    chk("lu_stall_cnt", 64'(stall_cnt), 64'(1));

    // ALU result forwarded into EX operand b.
    set_idle();
    bus.ex_regwrite = 1'b1; bus.ex_rd = 3; bus.id_rs2 = 3; bus.id_use_rs2 = 1'b1;
    cycle();
    chk("alu_ex_fwd_b", 64'(bus.ex_fwd_b), 64'(1));

    // Branch right behind an ALU op, with a redirect pending.
    set_idle();
    bus.id_is_branch = 1'b1; bus.id_redirect = 1'b1;
    bus.ex_regwrite = 1'b1; bus.ex_rd = 7; bus.id_rs1 = 7; bus.id_use_rs1 = 1'b1;
    cycle();
    bus.ex_regwrite = 1'b0; bus.ex_rd = 0;
    bus.mem_rd = 7; bus.mem_regwrite = 1'b1;
    cycle();
    chk("br_id_fwd_a", 64'(bus.id_fwd_a), 64'(1));
    chk("br_flush", 64'(bus.if_id_flush), 64'(1));

    // x0 never forms a hazard or a forward.
    set_idle();
    bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 0;
    bus.mem_regwrite = 1'b1; bus.wb_regwrite = 1'b1;
    bus.id_rs1 = 0; bus.id_use_rs1 = 1'b1;
    cycle();
    cycle();
    chk("x0_pc_en", 64'(bus.pc_en), 64'(1));

    // Four-cycle memory wait.
    set_idle();
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
    repeat (4) cycle();
    bus.dmem_ready = 1'b1;
    cycle();
    chk("mw_state", 64'(state), 64'(0));
    chk("mw_wait_cnt", 64'(wait_cnt), 64'(4));

    // Asynchronous reset in the middle of a memory wait.
    bus.dmem_ready = 1'b0;
    repeat (2) cycle();
    reset = 1'b0;
    #1;
    chk("mw_async_state", 64'(state), 64'(0));
    chk("mw_async_wait_cnt", 64'(wait_cnt), 64'(0));
    #2;
    reset = 1'b1;
    model_reset();
    set_idle();

    // Randomized traffic; small register space to provoke frequent hazards.
    for (int i = 0; i < 400; i++) begin
      bus.id_rs1       = RegAw'($urandom_range(0, 3));
      bus.id_rs2       = RegAw'($urandom_range(0, 3));
      bus.id_use_rs1   = 1'($urandom_range(0, 1));
      bus.id_use_rs2   = 1'($urandom_range(0, 1));
      bus.id_is_branch = ($urandom_range(0, 3) == 0);
      bus.id_redirect  = ($urandom_range(0, 2) == 0);
      bus.ex_rd        = RegAw'($urandom_range(0, 3));
      bus.ex_regwrite  = 1'($urandom_range(0, 1));
      bus.ex_memread   = 1'($urandom_range(0, 1));
      bus.mem_rd       = RegAw'($urandom_range(0, 3));
      bus.mem_regwrite = 1'($urandom_range(0, 1));
      bus.mem_memread  = 1'($urandom_range(0, 1));
      bus.wb_rd        = RegAw'($urandom_range(0, 3));
      bus.wb_regwrite  = 1'($urandom_range(0, 1));
      bus.dmem_req     = ($urandom_range(0, 2) == 0);
      bus.dmem_ready   = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Timeout: eight waiting cycles in MWAIT kill the block until reset.
    set_idle();
    cycle();
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
    repeat (Timeout) cycle();
    chk("to_not_yet", 64'(state), 64'(1));
    cycle();
    chk("to_state", 64'(state), 64'(2));
    chk("to_mem_err", 64'(mem_err), 64'(1));
    bus.dmem_ready = 1'b1;
    repeat (3) cycle();
    do_reset();
    set_idle();
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
